// File: rtl/shift_left_sequencer_pkg.sv
// Shared definitions for the shift-left sequencer and its datapath.
//   WIDTH / AMT_W : operand and shift-amount widths (fixed by the datapath)
//   mode_e        : {sel1,sel0} shift mode encodings
//   state_e       : sequencer FSM states
package shift_left_sequencer_pkg;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_ROL = 2'b01,
        MODE_RCL = 2'b10,
        MODE_ASL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_left_sequencer_unit.sv
// shift_left_unit: combinational 1-bit shift-left step.
//   i_x        operand
//   i_sel      {sel1,sel0} mode (LSL / ROL / RCL / ASL)
//   i_cin      carry entering bit 0 in RCL mode
//   o_f        shifted operand
//   o_cout     bit shifted out of the MSB
//   o_overflow sign change on this step (MSB ^ MSB-1), meaningful for ASL
module shift_left_unit
    import shift_left_sequencer_pkg::*;
(
    input  logic [WIDTH-1:0] i_x,
    input  logic [1:0]       i_sel,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_f,
    output logic             o_cout,
    output logic             o_overflow
);

    logic w_fill;

    // Bit entering at position 0: MSB for rotate, carry for rotate-through-carry.
    always_comb begin
        w_fill = 1'b0;
        case (i_sel)
            MODE_ROL: w_fill = i_x[WIDTH-1];
            MODE_RCL: w_fill = i_cin;
            default:  w_fill = 1'b0;
        endcase
    end

    assign o_f        = {i_x[WIDTH-2:0], w_fill};
    assign o_cout     = i_x[WIDTH-1];
    assign o_overflow = i_x[WIDTH-1] ^ i_x[WIDTH-2];

endmodule

// File: rtl/shift_left_sequencer.sv
// shift_left_sequencer: runs the 1-bit shift_left_unit for AMOUNT cycles.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           request, sampled only in IDLE
//   i_mode            00 LSL, 01 ROL, 10 RCL, 11 ASL
//   i_amount          number of 1-bit steps
//   i_x_in, i_cin     operand and initial carry (carry used by RCL only)
//   o_busy            high in SHIFT and DONE
//   o_done            one-cycle pulse, result valid
//   o_result, o_cout  shifted value and last bit out of the MSB
//   o_overflow        sticky ASL overflow, 0 in other modes
module shift_left_sequencer
    import shift_left_sequencer_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [AMT_W-1:0] i_amount,
    input  logic [WIDTH-1:0] i_x_in,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_overflow
);

    state_e           r_state, w_next;
    logic [1:0]       r_mode;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_operand;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_f;
    logic             w_dp_cout;
    logic             w_dp_ovf;

    shift_left_unit u_unit (
        .i_x        (r_operand),
        .i_sel      (r_mode),
        .i_cin      (r_carry),
        .o_f        (w_f),
        .o_cout     (w_dp_cout),
        .o_overflow (w_dp_ovf)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = (i_amount != '0) ? SHIFT : DONE;
            SHIFT:   if (r_cnt == AMT_W'(1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_mode    <= '0;
            r_cnt     <= '0;
            r_operand <= '0;
            r_carry   <= 1'b0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mode    <= i_mode;
                        r_cnt     <= i_amount;
                        r_operand <= i_x_in;
                        r_carry   <= i_cin;
                        r_cout    <= 1'b0;
                        r_ovf     <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_operand <= w_f;
                    r_cout    <= w_dp_cout;
                    // Carry only participates in the 9-bit rotate.
                    if (r_mode == MODE_RCL) r_carry <= w_dp_cout;
                    if (r_mode == MODE_ASL) r_ovf   <= r_ovf | w_dp_ovf;
                    r_cnt <= r_cnt - AMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // The operand register only moves on an accepted start or a shift step,
    // so it already holds the result stable from DONE until the next start.
    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == DONE);
    assign o_result   = r_operand;
    assign o_cout     = r_cout;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_shift_left_sequencer.sv
module tb_shift_left_sequencer;
    import shift_left_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [2:0] amount;
    logic [7:0] x_in;
    logic       cin;
    logic       busy, done, cout, overflow;
    logic [7:0] result;

    shift_left_sequencer dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_mode     (mode),
        .i_amount   (amount),
        .i_x_in     (x_in),
        .i_cin      (cin),
        .o_busy     (busy),
        .o_done     (done),
        .o_result   (result),
        .o_cout     (cout),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       co;
        logic       ov;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference: step-by-step shift of the operand.
    function automatic exp_t model(input logic [1:0] m, input logic [2:0] a,
                                   input logic [7:0] x, input logic c);
        exp_t e;
        logic [7:0] op;
        logic car, nb;
        op = x; car = c;
        e.co = 1'b0; e.ov = 1'b0;
        for (int i = 0; i < int'(a); i++) begin
            e.co = op[7];
            if (m == 2'b11) e.ov = e.ov | (op[7] ^ op[6]);
            nb = (m == 2'b01) ? op[7] : (m == 2'b10) ? car : 1'b0;
            if (m == 2'b10) car = op[7];
            op = {op[6:0], nb};
        end
        e.res = op;
        e.lat = int'(a) + 1;
        return e;
    endfunction

    task automatic run_op(input logic [1:0] m, input logic [2:0] a, input logic [7:0] x,
                          input logic c, input bit poke, input string name);
        exp_t e;
        int   lat;
        bit   seen;
        sb.push_back(model(m, a, x, c));
        @(negedge clk);
        start = 1'b1; mode = m; amount = a; x_in = x; cin = c;
        @(posedge clk);
        #1;
        // Scramble inputs: the operation in flight must not see them.
        start = 1'b0; mode = ~m; amount = ~a; x_in = ~x; cin = ~c;
        seen = 0; lat = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) seen = 1;
            else begin
                tests++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL %s busy_in_shift: got %b want 1", name, busy);
                end
                if (poke && lat == 2) begin
                    start = 1'b1; mode = 2'b01; amount = 3'd7; x_in = 8'h55; cin = 1'b1;
                end else start = 1'b0;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s done_timeout: no done within %0d cycles", name, lat);
            return;
        end
        if (lat !== e.lat) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
        end
        tests++;
        if (result !== e.res) begin
            fails++;
            $display("FAIL %s result: got %h want %h", name, result, e.res);
        end
        tests++;
        if (cout !== e.co) begin
            fails++;
            $display("FAIL %s cout: got %b want %b", name, cout, e.co);
        end
        tests++;
        if (overflow !== e.ov) begin
            fails++;
            $display("FAIL %s overflow: got %b want %b", name, overflow, e.ov);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_in_done: got %b want 1", name, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s done_pulse_width: got done=%b busy=%b want 0 0", name, done, busy);
        end
        tests++;
        if (result !== e.res || cout !== e.co || overflow !== e.ov) begin
            fails++;
            $display("FAIL %s hold_after_done: got %h/%b/%b want %h/%b/%b",
                     name, result, cout, overflow, e.res, e.co, e.ov);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 2'b00; amount = 3'd0; x_in = 8'h00; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy, done, result, cout, overflow} !== 12'h000) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h cout=%b ovf=%b want all 0",
                     busy, done, result, cout, overflow);
        end
    endtask

    task automatic test_lsl();
        run_op(2'b00, 3'd3, 8'h01, 1'b0, 0, "lsl");
    endtask

    task automatic test_rol();
        run_op(2'b01, 3'd2, 8'h81, 1'b0, 0, "rol");
        run_op(2'b01, 3'd1, 8'h81, 1'b0, 0, "rol_cout1");
    endtask

    task automatic test_rcl();
        run_op(2'b10, 3'd2, 8'h80, 1'b1, 0, "rcl");
        run_op(2'b10, 3'd7, 8'h5A, 1'b1, 0, "rcl_max");
    endtask

    task automatic test_asl();
        run_op(2'b11, 3'd1, 8'h40, 1'b0, 0, "asl_ovf");
        run_op(2'b11, 3'd2, 8'h10, 1'b0, 0, "asl_noovf");
        run_op(2'b11, 3'd3, 8'h60, 1'b0, 0, "asl_sticky");
    endtask

    task automatic test_zero();
        run_op(2'b00, 3'd1, 8'h80, 1'b0, 0, "lsl_cout1");
        run_op(2'b11, 3'd0, 8'hA5, 1'b1, 0, "zero_amt");
    endtask

    task automatic test_busy_ignore();
        run_op(2'b00, 3'd5, 8'h01, 1'b0, 1, "busy_start");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; mode = 2'b10; amount = 3'd7; x_in = 8'hFF; cin = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({busy, done, result, cout, overflow} !== 12'h000) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b result=%h cout=%b ovf=%b want all 0",
                     busy, done, result, cout, overflow);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_no_done: got done=%b at cycle %0d want 0", done, i);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++)
            run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0, "random");
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_rol();
        test_rcl();
        test_asl();
        test_zero();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
